fifo_param: RTL

//  Parametrised synchronous FIFO for the chargen datapath; generalises the 4-deep byte FIFO

---
 rtl/fifo_param.sv | 102 ++++++++++
 1 files changed

// File: rtl/fifo_param.sv
// ============================================================================
// Module  : fifo_param
// Brief   : Parametrised synchronous FIFO with level, almost flags and sticky
//           error flags. Define FIFO_PARAM_FWFT_EN for first-word-fall-through.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AE_LEVEL = 1,
  parameter int AF_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       n_wr,
  input  logic                       n_rd,
  input  logic [WIDTH-1:0]           port_in,
  output logic [WIDTH-1:0]           port_out,
  output logic                       n_empty,
  output logic                       n_full,
  output logic                       n_aempty,
  output logic                       n_afull,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic                       udf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);
  localparam logic [LW-1:0] AE_LV    = LW'(AE_LEVEL);
  localparam logic [LW-1:0] AF_LV    = LW'(AF_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rp;
  logic [PW-1:0]    wp;
  logic             wr_ok;
  logic             rd_ok;

  // A write into a full FIFO is still accepted when a read frees the head slot.
  always_comb begin
    rd_ok = !n_rd && (level != '0);
    wr_ok = !n_wr && ((level != DEPTH_LV) || rd_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wp] <= port_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wp <= wp + 1'b1;
      end
      if (rd_ok) begin
        rp <= rp + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (!n_wr && !wr_ok) begin
        ovf <= 1'b1;
      end
      if (!n_rd && !rd_ok) begin
        udf <= 1'b1;
      end
    end
  end

`ifdef FIFO_PARAM_FWFT_EN
  assign port_out = (level != '0) ? mem[rp] : '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      port_out <= '0;
    end else if (rd_ok) begin
      port_out <= mem[rp];
    end
  end
`endif

  // Flags decode the level register only, so strobes never reach them combinationally.
  assign n_empty  = (level != '0);
  assign n_full   = (level != DEPTH_LV);
  assign n_aempty = (level > AE_LV);
  assign n_afull  = (level < AF_LV);

endmodule

`default_nettype wire
